// File: rtl/banco_reg_tomasulo.sv
// Tomasulo architectural register file: per-register value, busy bit and producer tag.
// Latency: reads are combinational (0 cycles), with optional same-cycle CDB forwarding; state, busy_vec and busy_cnt update on the next edge.
// Backpressure: none; issue, CDB, direct write and flush are accepted every cycle.
module banco_reg_tomasulo #(
    parameter int DATA_W  = 16,
    parameter int NREG    = 8,
    parameter int TAG_W   = 3,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [AW-1:0]     rd_addr1,
    input  logic [AW-1:0]     rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic [TAG_W-1:0]  rd_tag1,
    output logic [TAG_W-1:0]  rd_tag2,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_reg,
    input  logic [TAG_W-1:0]  iss_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    output logic [NREG-1:0]   busy_vec,
    output logic [AW:0]       busy_cnt
);

    logic [DATA_W-1:0] data_q [NREG];
    logic [DATA_W-1:0] data_d [NREG];
    logic [TAG_W-1:0]  tag_q  [NREG];
    logic [TAG_W-1:0]  tag_d  [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [AW:0]       cnt_q, cnt_d;

    logic [NREG-1:0]   cdb_hit, iss_hit, wr_hit;

    always_comb begin
        cdb_hit = '0;
        iss_hit = '0;
        wr_hit  = '0;
        for (int r = 0; r < NREG; r++) begin
            cdb_hit[r] = cdb_valid && busy_q[r] && (tag_q[r] == cdb_tag);
            iss_hit[r] = iss_en && (iss_reg == AW'(r));
            wr_hit[r]  = wr_en && (wr_addr == AW'(r));
        end
    end

    // Each register resolves flush > issue > CDB retire > direct write; CDB data always beats wr_data.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = '0;
        for (int r = 0; r < NREG; r++) begin
            data_d[r] = data_q[r];
            tag_d[r]  = tag_q[r];
            if (flush) begin
                busy_d[r] = 1'b0;
                if (cdb_hit[r]) begin
                    data_d[r] = cdb_data;
                end else if (wr_hit[r]) begin
                    data_d[r] = wr_data;
                end
            end else if (iss_hit[r]) begin
                busy_d[r] = 1'b1;
                tag_d[r]  = iss_tag;
                if (cdb_hit[r]) begin
                    data_d[r] = cdb_data;
                end
            end else if (cdb_hit[r]) begin
                busy_d[r] = 1'b0;
                data_d[r] = cdb_data;
            end else if (wr_hit[r]) begin
                busy_d[r] = 1'b0;
                data_d[r] = wr_data;
            end
            if (R0_ZERO != 0 && r == 0) begin
                busy_d[r] = 1'b0;
                data_d[r] = '0;
                tag_d[r]  = '0;
            end
            cnt_d = cnt_d + (AW+1)'(busy_d[r]);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
            cnt_q  <= '0;
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= data_d[r];
                tag_q[r]  <= tag_d[r];
            end
        end
    end

    // Forwarding only turns a busy-and-matching entry into a ready value; issue/write stay invisible until the edge.
    always_comb begin
        rd_data1 = data_q[rd_addr1];
        rd_busy1 = busy_q[rd_addr1];
        rd_tag1  = tag_q[rd_addr1];
        if (BYPASS != 0 && cdb_hit[rd_addr1]) begin
            rd_data1 = cdb_data;
            rd_busy1 = 1'b0;
        end
    end

    always_comb begin
        rd_data2 = data_q[rd_addr2];
        rd_busy2 = busy_q[rd_addr2];
        rd_tag2  = tag_q[rd_addr2];
        if (BYPASS != 0 && cdb_hit[rd_addr2]) begin
            rd_data2 = cdb_data;
            rd_busy2 = 1'b0;
        end
    end

    assign busy_vec = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_banco_reg_tomasulo.sv
// Directed bench for banco_reg_tomasulo: default instance plus a 16x32 instance with a hardwired zero register.
// Expected values are queued as stimulus is driven and popped against the observed outputs.
module tb_banco_reg_tomasulo;

    logic        clock = 1'b0;
    logic        resetn;
    logic [2:0]  rd_addr1, rd_addr2;
    logic [15:0] rd_data1, rd_data2;
    logic        rd_busy1, rd_busy2;
    logic [2:0]  rd_tag1, rd_tag2;
    logic        iss_en;
    logic [2:0]  iss_reg, iss_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        flush;
    logic [7:0]  busy_vec;
    logic [3:0]  busy_cnt;

    logic [3:0]  x_rd_addr1, x_rd_addr2;
    logic [31:0] x_rd_data1, x_rd_data2;
    logic        x_rd_busy1, x_rd_busy2;
    logic [2:0]  x_rd_tag1, x_rd_tag2;
    logic        x_iss_en;
    logic [3:0]  x_iss_reg;
    logic [2:0]  x_iss_tag;
    logic        x_cdb_valid;
    logic [2:0]  x_cdb_tag;
    logic [31:0] x_cdb_data;
    logic        x_wr_en;
    logic [3:0]  x_wr_addr;
    logic [31:0] x_wr_data;
    logic        x_flush;
    logic [15:0] x_busy_vec;
    logic [4:0]  x_busy_cnt;

    banco_reg_tomasulo u_dut (
        .clock(clock), .resetn(resetn),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .rd_tag1(rd_tag1), .rd_tag2(rd_tag2),
        .iss_en(iss_en), .iss_reg(iss_reg), .iss_tag(iss_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flush(flush), .busy_vec(busy_vec), .busy_cnt(busy_cnt)
    );

    banco_reg_tomasulo #(.DATA_W(32), .NREG(16), .TAG_W(3), .BYPASS(1), .R0_ZERO(1)) u_dut16 (
        .clock(clock), .resetn(resetn),
        .rd_addr1(x_rd_addr1), .rd_addr2(x_rd_addr2),
        .rd_data1(x_rd_data1), .rd_data2(x_rd_data2),
        .rd_busy1(x_rd_busy1), .rd_busy2(x_rd_busy2),
        .rd_tag1(x_rd_tag1), .rd_tag2(x_rd_tag2),
        .iss_en(x_iss_en), .iss_reg(x_iss_reg), .iss_tag(x_iss_tag),
        .cdb_valid(x_cdb_valid), .cdb_tag(x_cdb_tag), .cdb_data(x_cdb_data),
        .wr_en(x_wr_en), .wr_addr(x_wr_addr), .wr_data(x_wr_data),
        .flush(x_flush), .busy_vec(x_busy_vec), .busy_cnt(x_busy_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic sb_push(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL sb_empty observed=%h required=<queued expectation>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s observed=%h required=%h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        iss_en = 1'b0; cdb_valid = 1'b0; wr_en = 1'b0; flush = 1'b0;
        x_iss_en = 1'b0; x_cdb_valid = 1'b0; x_wr_en = 1'b0; x_flush = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        rd_addr1 = 3'd3; rd_addr2 = 3'd0;
        iss_reg = '0; iss_tag = '0; cdb_tag = '0; cdb_data = '0; wr_addr = '0; wr_data = '0;
        x_rd_addr1 = '0; x_rd_addr2 = '0;
        x_iss_reg = '0; x_iss_tag = '0; x_cdb_tag = '0; x_cdb_data = '0; x_wr_addr = '0; x_wr_data = '0;
        idle();
        #3;
        sb_push("reset_data", 32'h0);   sb_check(32'(rd_data1));
        sb_push("reset_busy", 32'h0);   sb_check(32'(rd_busy1));
        sb_push("reset_vec", 32'h0);    sb_check(32'(busy_vec));
        sb_push("reset_cnt", 32'h0);    sb_check(32'(busy_cnt));
        #9 resetn = 1'b1;

        // T1: fill regs, rename r2, then pulse reset mid-cycle
        for (int r = 1; r < 8; r++) begin
            wr_en = 1'b1; wr_addr = 3'(r); wr_data = 16'(16'h1111 * r);
            step();
        end
        wr_en = 1'b0;
        iss_en = 1'b1; iss_reg = 3'd2; iss_tag = 3'd1;
        step();
        idle();
        rd_addr1 = 3'd7; rd_addr2 = 3'd2;
        #1;
        sb_push("t1_r7_pre", 32'h7777); sb_check(32'(rd_data1));
        sb_push("t1_r2_busy", 32'h1);   sb_check(32'(rd_busy2));
        sb_push("t1_cnt_pre", 32'h1);   sb_check(32'(busy_cnt));
        #1 resetn = 1'b0;
        #1;
        for (int r = 1; r < 8; r++) begin
            rd_addr1 = 3'(r);
            #0;
            sb_push($sformatf("t1_rst_r%0d", r), 32'h0); sb_check(32'(rd_data1));
        end
        sb_push("t1_rst_busy", 32'h0); sb_check(32'(rd_busy2));
        sb_push("t1_rst_cnt", 32'h0);  sb_check(32'(busy_cnt));
        #1 resetn = 1'b1;

        // T2: rename then retire
        iss_en = 1'b1; iss_reg = 3'd3; iss_tag = 3'd5;
        step();
        idle();
        rd_addr1 = 3'd3;
        #1;
        sb_push("t2_busy", 32'h1); sb_check(32'(rd_busy1));
        sb_push("t2_tag", 32'h5);  sb_check(32'(rd_tag1));
        sb_push("t2_cnt", 32'h1);  sb_check(32'(busy_cnt));
        cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'hBEEF;
        step();
        idle();
        #1;
        sb_push("t2_data", 32'hBEEF); sb_check(32'(rd_data1));
        sb_push("t2_free", 32'h0);    sb_check(32'(rd_busy1));
        sb_push("t2_cnt0", 32'h0);    sb_check(32'(busy_cnt));

        // T3: two registers on the same tag, forwarded in the broadcast cycle
        iss_en = 1'b1; iss_reg = 3'd2; iss_tag = 3'd4;
        step();
        iss_reg = 3'd6;
        step();
        idle();
        sb_push("t3_cnt2", 32'h2); sb_check(32'(busy_cnt));
        rd_addr1 = 3'd2; rd_addr2 = 3'd6;
        cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h00A5;
        #1;
        sb_push("t3_byp_data", 32'h00A5); sb_check(32'(rd_data1));
        sb_push("t3_byp_busy", 32'h0);    sb_check(32'(rd_busy1));
        sb_push("t3_byp_data2", 32'h00A5); sb_check(32'(rd_data2));
        step();
        idle();
        #1;
        sb_push("t3_r2", 32'h00A5); sb_check(32'(rd_data1));
        sb_push("t3_r6", 32'h00A5); sb_check(32'(rd_data2));
        sb_push("t3_r6_free", 32'h0); sb_check(32'(rd_busy2));
        sb_push("t3_cnt0", 32'h0); sb_check(32'(busy_cnt));

        // T4: re-issue and retire of the old tag on the same edge
        iss_en = 1'b1; iss_reg = 3'd1; iss_tag = 3'd2;
        step();
        iss_tag = 3'd7;
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'h1234;
        step();
        idle();
        rd_addr1 = 3'd1;
        #1;
        sb_push("t4_data", 32'h1234); sb_check(32'(rd_data1));
        sb_push("t4_busy", 32'h1);    sb_check(32'(rd_busy1));
        sb_push("t4_tag", 32'h7);     sb_check(32'(rd_tag1));
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'h9999;
        step();
        idle();
        #1;
        sb_push("t4_stale_data", 32'h1234); sb_check(32'(rd_data1));
        sb_push("t4_stale_busy", 32'h1);    sb_check(32'(rd_busy1));

        // T5: flush with four busy registers and a concurrent issue
        iss_en = 1'b1;
        for (int r = 2; r < 5; r++) begin
            iss_reg = 3'(r); iss_tag = 3'(r - 1);
            step();
        end
        idle();
        sb_push("t5_cnt4", 32'h4);  sb_check(32'(busy_cnt));
        sb_push("t5_vec", 32'h1E);  sb_check(32'(busy_vec));
        flush = 1'b1; iss_en = 1'b1; iss_reg = 3'd5; iss_tag = 3'd1;
        step();
        idle();
        rd_addr2 = 3'd5;
        #1;
        sb_push("t5_vec0", 32'h0);   sb_check(32'(busy_vec));
        sb_push("t5_cnt0", 32'h0);   sb_check(32'(busy_cnt));
        sb_push("t5_r5_busy", 32'h0); sb_check(32'(rd_busy2));

        // Broadcast with no waiting register leaves state alone
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'hFFFF;
        rd_addr1 = 3'd3;
        step();
        idle();
        #1;
        sb_push("nomatch_r3", 32'hBEEF); sb_check(32'(rd_data1));

        // T6: wide instance with register 0 tied to zero
        x_wr_en = 1'b1; x_wr_addr = 4'd0; x_wr_data = 32'hFFFF_FFFF;
        step();
        idle();
        x_iss_en = 1'b1; x_iss_reg = 4'd0; x_iss_tag = 3'd3;
        step();
        idle();
        x_wr_en = 1'b1; x_wr_addr = 4'd15; x_wr_data = 32'hDEAD_BEEF;
        step();
        idle();
        x_rd_addr1 = 4'd0; x_rd_addr2 = 4'd15;
        #1;
        sb_push("t6_r0_data", 32'h0);        sb_check(x_rd_data1);
        sb_push("t6_r0_busy", 32'h0);        sb_check(32'(x_rd_busy1));
        sb_push("t6_cnt", 32'h0);            sb_check(32'(x_busy_cnt));
        sb_push("t6_r15", 32'hDEAD_BEEF);    sb_check(x_rd_data2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
